lb_dispatcher: RTL and testbench

Parametrised request dispatcher for the load balancer: accepts HTTP metadata beats on an AXI4-Stream input, buffers them in a QDEPTH-entry FIFO, and for each buffered request selects a target region from live per-region statistics (hosted operator id, current load). It prefers regions already hosting the requested operator. It can optionally trigger partial reconfiguration when no region hosts that operator. It sits between the HTTP front end and the region crossbar, generalising the fixed four-region, fixed-width selection to N regions, configurable widths and a selectable tie-break policy.

---
 rtl/lb_dispatcher.sv | 255 +++++++++++++++++++++++++
 tb/tb_lb_dispatcher.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_dispatcher.sv
// lb_dispatcher: buffers HTTP metadata beats in a QDEPTH-entry FIFO and
// dispatches each one to a region chosen from live per-region statistics.
// Regions already hosting the requested operator are preferred; among them
// the least-loaded one wins, with ties broken by lowest index (TIE_RR=0) or
// round-robin after the last dispatched region (TIE_RR=1).
// Optional feature macro: LB_PR_REQ_EN. When defined, a request with no
// hosting region triggers a partial-reconfiguration request to an idle
// region. When undefined, such a request falls back to the least-loaded
// non-full region, and the pr_req_* outputs are tied to 0.
module lb_dispatcher #(
    parameter int META_W    = 8,
    parameter int OID_W     = 2,
    parameter int LOAD_W    = 2,
    parameter int N_REGIONS = 4,
    parameter int QDEPTH    = 4,
    parameter int TIE_RR    = 0
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  meta_in_tvalid,
    output logic                                  meta_in_tready,
    input  logic [META_W-1:0]                     meta_in_tdata,
    input  logic [N_REGIONS*(OID_W+LOAD_W)-1:0]   region_stats_in,
    output logic                                  disp_tvalid,
    input  logic                                  disp_tready,
    output logic [META_W-1:0]                     disp_tdata,
    output logic [$clog2(N_REGIONS)-1:0]          disp_region,
    output logic                                  pr_req_valid,
    output logic [$clog2(N_REGIONS)-1:0]          pr_req_region,
    output logic [OID_W-1:0]                      pr_req_oid,
    input  logic                                  pr_done
);

    localparam int RW = $clog2(N_REGIONS);
    localparam int SW = OID_W + LOAD_W;
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [LOAD_W-1:0] LOAD_FULL = '1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PR_REQ,
        PR_WAIT,
        DISPATCH
    } state_t;

    state_t state, state_next;

    // ---------------------------------------------------------------
    // Metadata FIFO
    // ---------------------------------------------------------------
    logic [META_W-1:0] mem [QDEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic              tready_q;
    logic              wr_en, rd_en;
    logic [META_W-1:0] head;
    logic [OID_W-1:0]  head_oid;

    assign wr_en      = meta_in_tvalid && tready_q;
    assign rd_en      = (state == DISPATCH) && disp_tready;
    assign count_next = count + CW'(wr_en) - CW'(rd_en);
    assign head       = mem[rd_ptr];
    assign head_oid   = head[OID_W-1:0];

    // Write accepted beats into the storage array.
    // NOTE: the storage array is deliberately left out of reset; every entry
    // is written before the read pointer can reach it, so only the pointers
    // and count need a known value.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= meta_in_tdata;
        end
    end

    // Track pointers, occupancy and the registered ready flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tready_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            tready_q <= (count_next != CW'(QDEPTH));
        end
    end

    assign meta_in_tready = tready_q;

    // ---------------------------------------------------------------
    // Region selection
    // ---------------------------------------------------------------
    // Returns {found, index}: the minimum-load region among 'mask', ties
    // broken by lowest index or by the first index strictly after 'rr'.
    function automatic logic [RW:0] pick_region(
        input logic [N_REGIONS-1:0]             mask,
        input logic [N_REGIONS-1:0][LOAD_W-1:0] loads,
        input logic [RW-1:0]                    rr
    );
        logic [LOAD_W-1:0]    min_load;
        logic [N_REGIONS-1:0] tied;
        logic [RW-1:0]        idx;
        int                   cand;
        min_load = '1;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (mask[i] && (loads[i] < min_load)) min_load = loads[i];
        end
        for (int i = 0; i < N_REGIONS; i++) begin
            tied[i] = mask[i] && (loads[i] == min_load);
        end
        idx = '0;
        if (TIE_RR != 0) begin
            // Walk backwards so the nearest index after rr is written last.
            for (int k = N_REGIONS; k >= 1; k--) begin
                cand = (int'(rr) + k) % N_REGIONS;
                if (tied[cand]) idx = RW'(cand);
            end
        end else begin
            for (int i = N_REGIONS - 1; i >= 0; i--) begin
                if (tied[i]) idx = RW'(i);
            end
        end
        return {|tied, idx};
    endfunction

    logic [N_REGIONS-1:0][LOAD_W-1:0] loads;
    logic [N_REGIONS-1:0]             match_mask;
    logic [N_REGIONS-1:0]             alt_mask;
    logic [RW:0]                      match_pick, alt_pick;
    logic [RW-1:0]                    rr_ptr, rr_next;

    // Decode region statistics and pick the preferred and fallback regions.
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        loads      = '0;
        match_mask = '0;
        alt_mask   = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            loads[i]      = region_stats_in[i*SW +: LOAD_W];
            match_mask[i] = (region_stats_in[i*SW+LOAD_W +: OID_W] == head_oid)
                            && (loads[i] != LOAD_FULL);
`ifdef LB_PR_REQ_EN
            alt_mask[i]   = (loads[i] == '0);
`else
            alt_mask[i]   = (loads[i] != LOAD_FULL);
`endif
        end
        match_pick = pick_region(match_mask, loads, rr_ptr);
        alt_pick   = pick_region(alt_mask, loads, rr_ptr);
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    logic [RW-1:0] disp_region_q, disp_region_next;
`ifdef LB_PR_REQ_EN
    logic [RW-1:0]    pr_region_q, pr_region_next;
    logic [OID_W-1:0] pr_oid_q, pr_oid_next;
`else
    logic             unused_pr_done;
    assign unused_pr_done = pr_done;
`endif

    // Next-state and next-register logic for selection, PR and dispatch.
    always_comb begin
        state_next       = state;
        disp_region_next = disp_region_q;
        rr_next          = rr_ptr;
`ifdef LB_PR_REQ_EN
        pr_region_next   = pr_region_q;
        pr_oid_next      = pr_oid_q;
`endif
        case (state)
            IDLE: begin
                if (count != '0) state_next = SELECT;
            end
            SELECT: begin
                if (match_pick[RW]) begin
                    disp_region_next = match_pick[RW-1:0];
                    state_next       = DISPATCH;
                end else if (alt_pick[RW]) begin
`ifdef LB_PR_REQ_EN
                    pr_region_next   = alt_pick[RW-1:0];
                    pr_oid_next      = head_oid;
                    state_next       = PR_REQ;
`else
                    disp_region_next = alt_pick[RW-1:0];
                    state_next       = DISPATCH;
`endif
                end
            end
`ifdef LB_PR_REQ_EN
            PR_REQ: begin
                state_next = PR_WAIT;
            end
            PR_WAIT: begin
                if (pr_done) begin
                    disp_region_next = pr_region_q;
                    state_next       = DISPATCH;
                end
            end
`endif
            DISPATCH: begin
                if (disp_tready) begin
                    rr_next    = disp_region_q;
                    state_next = (count_next != '0) ? SELECT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register FSM state, chosen regions and the round-robin pointer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            disp_region_q <= '0;
            rr_ptr        <= RW'(N_REGIONS - 1);
`ifdef LB_PR_REQ_EN
            pr_region_q   <= '0;
            pr_oid_q      <= '0;
`endif
        end else begin
            state         <= state_next;
            disp_region_q <= disp_region_next;
            rr_ptr        <= rr_next;
`ifdef LB_PR_REQ_EN
            pr_region_q   <= pr_region_next;
            pr_oid_q      <= pr_oid_next;
`endif
        end
    end

    assign disp_tvalid = (state == DISPATCH);
    assign disp_tdata  = disp_tvalid ? head : '0;
    assign disp_region = disp_region_q;

`ifdef LB_PR_REQ_EN
    assign pr_req_valid  = (state == PR_REQ);
    assign pr_req_region = pr_region_q;
    assign pr_req_oid    = pr_oid_q;
`else
    assign pr_req_valid  = 1'b0;
    assign pr_req_region = '0;
    assign pr_req_oid    = '0;
`endif

endmodule

// File: tb/tb_lb_dispatcher.sv
// Directed testbench for lb_dispatcher. Two instances share all inputs:
// dut_a uses lowest-index tie-break, dut_b uses round-robin tie-break.
// Expectations follow the LB_PR_REQ_EN setting of the build.
`timescale 1ns/1ps
module tb_lb_dispatcher;

    logic        aclk = 1'b0;
    logic        areset;
    logic        meta_in_tvalid;
    logic [7:0]  meta_in_tdata;
    logic [15:0] region_stats_in;
    logic        disp_tready;
    logic        pr_done;

    logic       tready_a, tvalid_a, pr_valid_a;
    logic [7:0] tdata_a;
    logic [1:0] region_a, pr_region_a, pr_oid_a;
    logic       tready_b, tvalid_b, pr_valid_b;
    logic [7:0] tdata_b;
    logic [1:0] region_b, pr_region_b, pr_oid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    lb_dispatcher #(.TIE_RR(0)) dut_a (
        .aclk(aclk), .areset(areset),
        .meta_in_tvalid(meta_in_tvalid), .meta_in_tready(tready_a),
        .meta_in_tdata(meta_in_tdata), .region_stats_in(region_stats_in),
        .disp_tvalid(tvalid_a), .disp_tready(disp_tready),
        .disp_tdata(tdata_a), .disp_region(region_a),
        .pr_req_valid(pr_valid_a), .pr_req_region(pr_region_a),
        .pr_req_oid(pr_oid_a), .pr_done(pr_done)
    );

    lb_dispatcher #(.TIE_RR(1)) dut_b (
        .aclk(aclk), .areset(areset),
        .meta_in_tvalid(meta_in_tvalid), .meta_in_tready(tready_b),
        .meta_in_tdata(meta_in_tdata), .region_stats_in(region_stats_in),
        .disp_tvalid(tvalid_b), .disp_tready(disp_tready),
        .disp_tdata(tdata_b), .disp_region(region_b),
        .pr_req_valid(pr_valid_b), .pr_req_region(pr_region_b),
        .pr_req_oid(pr_oid_b), .pr_done(pr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic push(input logic [7:0] d);
        meta_in_tvalid = 1'b1;
        meta_in_tdata  = d;
        tick();
        meta_in_tvalid = 1'b0;
    endtask

    // Bounded wait for a dispatch on both instances.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (tvalid_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid_a"}, tvalid_a, 1);
        check({tag, "_valid_b"}, tvalid_b, 1);
    endtask

    task automatic check_disp(input string tag, input logic [7:0] d,
                              input logic [1:0] ra, input logic [1:0] rb);
        check({tag, "_data_a"}, tdata_a, d);
        check({tag, "_data_b"}, tdata_b, d);
        check({tag, "_region_a"}, region_a, ra);
        check({tag, "_region_b"}, region_b, rb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] beats [5];
        logic [1:0] exp_reg [4];
        int n;
        beats   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        exp_reg = '{2'd2, 2'd3, 2'd0, 2'd1};

        areset          = 1'b1;
        meta_in_tvalid  = 1'b0;
        meta_in_tdata   = 8'h00;
        region_stats_in = 16'h0000;
        disp_tready     = 1'b0;
        pr_done         = 1'b0;

        // Reset values.
        tick(); tick(); tick();
        check("rst_tready_a", tready_a, 0);
        check("rst_tready_b", tready_b, 0);
        check("rst_tvalid", tvalid_a, 0);
        check("rst_tdata", tdata_a, 0);
        check("rst_region", region_a, 0);
        check("rst_pr_valid", pr_valid_a, 0);
        check("rst_pr_region", pr_region_a, 0);
        check("rst_pr_oid", pr_oid_a, 0);
        areset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("idle_tready", tready_a, 1);
            check("idle_tvalid", tvalid_a, 0);
            tick();
        end

        // Match with latency: edge t accept, SELECT at t+1, DISPATCH at t+2.
        region_stats_in = 16'h369C;
        disp_tready     = 1'b1;
        push(8'hA9);
        check("lat_t_tvalid", tvalid_a, 0);
        tick();
        check("lat_t1_tvalid", tvalid_a, 0);
        tick();
        check("lat_t2_tvalid_a", tvalid_a, 1);
        check("lat_t2_tvalid_b", tvalid_b, 1);
        check_disp("match", 8'hA9, 2'd2, 2'd2);
        tick();
        check("match_done", tvalid_a, 0);

        // Tie-break: regions 0 and 2 host oid 1 at load 1.
        region_stats_in = 16'hC585;
        push(8'h41);
        push(8'h45);
        wait_valid("tie1");
        check_disp("tie1", 8'h41, 2'd0, 2'd0);
        tick();
        check("b2b_gap", tvalid_a, 0);
        tick();
        check("b2b_tvalid", tvalid_a, 1);
        check_disp("tie2", 8'h45, 2'd0, 2'd2);
        tick();
        check("tie_done", tvalid_a, 0);

        // Full FIFO with stalled consumer, then drain in order.
        region_stats_in = 16'hC840;
        disp_tready     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("full_tready_a", tready_a, (i < 4) ? 1 : 0);
            check("full_tready_b", tready_b, (i < 4) ? 1 : 0);
            meta_in_tvalid = 1'b1;
            meta_in_tdata  = beats[i];
            tick();
        end
        meta_in_tvalid = 1'b0;
        check("full_hold_tready", tready_a, 0);
        check("stall_hold_data", tdata_a, 8'hAA);
        tick();
        check("stall_hold_valid", tvalid_a, 1);
        check("stall_hold_data2", tdata_a, 8'hAA);
        disp_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("drain");
            check_disp("drain", beats[k], exp_reg[k], exp_reg[k]);
            tick();
        end
        check("drain_tready", tready_a, 1);
        tick(); tick(); tick();
        check("no_fifth_beat", tvalid_a, 0);

        // Stray pr_done outside PR_WAIT is ignored.
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        tick();
        check("stray_prdone_tvalid", tvalid_a, 0);
        check("stray_prdone_prv", pr_valid_a, 0);

        // No hosting region for oid 3; region 1 idle at load 0.
        region_stats_in = 16'h3906;
        push(8'h33);
`ifdef LB_PR_REQ_EN
        n = 0;
        while (pr_valid_a !== 1'b1 && n < 20) begin
            check("pr_wait_tvalid", tvalid_a, 0);
            tick();
            n++;
        end
        check("pr_valid_a", pr_valid_a, 1);
        check("pr_valid_b", pr_valid_b, 1);
        check("pr_region", pr_region_a, 1);
        check("pr_oid", pr_oid_a, 3);
        tick();
        check("pr_one_cycle", pr_valid_a, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pr_wait_hold", tvalid_a, 0);
        end
        tick();
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("pr_disp_valid", tvalid_a, 1);
        check_disp("pr_disp", 8'h33, 2'd1, 2'd1);
`else
        for (int i = 0; i < 2; i++) begin
            check("nomatch_prv_a", pr_valid_a, 0);
            check("nomatch_prv_b", pr_valid_b, 0);
            tick();
        end
        check("nomatch_valid", tvalid_a, 1);
        check("nomatch_prv_disp", pr_valid_a, 0);
        check_disp("nomatch", 8'h33, 2'd1, 2'd1);
`endif
        tick();
        check("nomatch_done", tvalid_a, 0);

        // All regions full: nothing dispatched until region 1 drops.
        region_stats_in = 16'hFB73;
        push(8'h01);
        for (int i = 0; i < 8; i++) begin
            check("allfull_tvalid", tvalid_a, 0);
            check("allfull_prv", pr_valid_a, 0);
            tick();
        end
        region_stats_in = 16'hFB63;
        wait_valid("unblock");
        check_disp("unblock", 8'h01, 2'd1, 2'd1);
        tick();

        // Reset mid-operation drops queued beats.
        disp_tready     = 1'b0;
        region_stats_in = 16'hC840;
        push(8'h11);
        push(8'h22);
        tick();
        check("pre_rst_valid", tvalid_a, 1);
        areset = 1'b1;
        #1;
        check("async_rst_tvalid", tvalid_a, 0);
        check("async_rst_tready", tready_a, 0);
        tick();
        areset  = 1'b0;
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_tvalid", tvalid_a, 0);
            check("post_rst_tready", tready_a, 1);
            tick();
        end

        // Round-robin pointer restarts at N_REGIONS-1 after reset.
        disp_tready     = 1'b1;
        region_stats_in = 16'hC585;
        push(8'h41);
        wait_valid("rr_rst");
        check_disp("rr_rst", 8'h41, 2'd0, 2'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
